// File: rtl/ps2_pkg.sv
// Shared PS2 definitions: FSM state encoding and frame geometry.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_fall_detect.sv
// Falling-edge detector for the debounced PS2 clock line.
// Shared by the receiver and the host-to-device transmitter.
module ps2_fall_detect (
  input  logic cclk,
  input  logic clr,
  input  logic ps2c,
  output logic fall
);

  logic ps2c_d;
  logic ps2c_q;

  // Next value of the delayed clock sample is simply the current line level.
  always_comb begin
    ps2c_d = ps2c;
  end

  // Delayed copy of ps2c; resets high so an idle line never looks like an edge.
  always_ff @(posedge cclk) begin
    if (clr) begin
      ps2c_q <= 1'b1;
    end else begin
      ps2c_q <= ps2c_d;
    end
  end

  assign fall = ps2c_q & ~ps2c;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS2 device-to-host frame receiver: start, 8 data bits LSB first, odd
// parity, stop. Produces one-cycle rx_done / frame_err strobes.
module ps2_frame_receiver #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       cclk,
  input  logic       clr,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] scan_code,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  import ps2_pkg::*;

  localparam int               TO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       LAST_BIT = 3'(PS2_DATA_BITS - 1);

  // Odd parity: data ones plus the parity bit must be an odd count.
  function automatic logic parity_ok(input logic [7:0] data, input logic par);
    return par ^ (^data);
  endfunction

  logic fall;

  ps2_state_e      state_q,     state_d;
  logic [2:0]      bit_cnt_q,   bit_cnt_d;
  logic [7:0]      shift_q,     shift_d;
  logic            par_ok_q,    par_ok_d;
  logic [TO_W-1:0] to_cnt_q,    to_cnt_d;
  logic [7:0]      scan_code_q, scan_code_d;
  logic            rx_done_q,   rx_done_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout_hit;

  ps2_fall_detect u_fall (
    .cclk (cclk),
    .clr  (clr),
    .ps2c (ps2c),
    .fall (fall)
  );

  // Next-state, datapath and strobe logic; a fall always beats the timeout.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    scan_code_d = scan_code_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    timeout_hit = (state_q != ST_IDLE) && !fall && (to_cnt_q == TO_LAST);

    if (state_q == ST_IDLE || fall) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    if (timeout_hit) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // A high data line at a clock fall is a glitch, not a start bit.
          if (fall && rx_en && !ps2d) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        ST_DATA: begin
          if (fall) begin
            shift_d   = {ps2d, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (fall) begin
            par_ok_d = parity_ok(shift_q, ps2d);
            state_d  = ST_STOP;
          end
        end
        ST_STOP: begin
          if (fall) begin
            state_d = ST_IDLE;
            if (ps2d && par_ok_q) begin
              scan_code_d = shift_q;
              rx_done_d   = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control state, counters and output strobes; clr discards any partial frame.
  always_ff @(posedge cclk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      scan_code_q <= 8'h00;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      par_ok_q    <= par_ok_d;
      to_cnt_q    <= to_cnt_d;
      scan_code_q <= scan_code_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Data shifter needs no reset: it is cleared whenever a start bit is accepted.
  always_ff @(posedge cclk) begin
    shift_q <= shift_d;
  end

  assign scan_code = scan_code_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver with a frame-level reference model.
module tb_ps2_frame_receiver;
  import ps2_pkg::*;

  localparam int TO = 32;

  logic       cclk = 1'b0;
  logic       clr  = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] scan_code;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int   n_done = 0;
  int   n_err  = 0;
  int   n_long = 0;
  int   n_both = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  logic [7:0] model_code = 8'h00;

  always #5 cclk = ~cclk;

  ps2_frame_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .cclk      (cclk),
    .clr       (clr),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .rx_en     (rx_en),
    .scan_code (scan_code),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Strobe monitor: counts pulses and flags stretched or overlapping strobes.
  always @(negedge cclk) begin
    if (rx_done === 1'b1) n_done <= n_done + 1;
    if (frame_err === 1'b1) n_err <= n_err + 1;
    if (rx_done === 1'b1 && frame_err === 1'b1) n_both <= n_both + 1;
    if ((rx_done === 1'b1 && prev_done) || (frame_err === 1'b1 && prev_err)) n_long <= n_long + 1;
    prev_done <= (rx_done === 1'b1);
    prev_err  <= (frame_err === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge cclk);
  endtask

  // One PS2 bit: data set up while the clock is high, then an 8-cycle clock period.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2d = bits[i];
      tick(2);
      ps2c = 1'b0;
      tick(4);
      ps2c = 1'b1;
      tick(2);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stop);
    return {stop, par, d, 1'b0};
  endfunction

  // Parity bit that makes the count of ones odd.
  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  // Frame accepted iff the stop bit is 1 and data plus parity hold an odd number of ones.
  function automatic logic model_ok(input logic [7:0] d, input logic par, input logic stop);
    int ones;
    ones = $countones(d) + (par ? 1 : 0);
    return stop && (ones % 2 == 1);
  endfunction

  task automatic check_frame(input string name, input logic [7:0] d, input logic par, input logic stop);
    int   d0;
    int   e0;
    logic ok;
    d0 = n_done;
    e0 = n_err;
    ok = model_ok(d, par, stop);
    send_bits(mk_frame(d, par, stop), PS2_FRAME_BITS);
    tick(2);
    if (ok) model_code = d;
    total++;
    if ((n_done - d0) !== (ok ? 1 : 0)) begin
      bad++;
      $display("FAIL %s rx_done_count got=%0d want=%0d", name, n_done - d0, ok ? 1 : 0);
    end
    total++;
    if ((n_err - e0) !== (ok ? 0 : 1)) begin
      bad++;
      $display("FAIL %s frame_err_count got=%0d want=%0d", name, n_err - e0, ok ? 0 : 1);
    end
    total++;
    if (scan_code !== model_code) begin
      bad++;
      $display("FAIL %s scan_code got=%h want=%h", name, scan_code, model_code);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_after got=%b want=0", name, busy);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    tick(3);
    total++;
    if ({scan_code, rx_done, frame_err, busy} !== 11'h000) begin
      bad++;
      $display("FAIL reset outputs got=%h/%b/%b/%b want=00/0/0/0", scan_code, rx_done, frame_err, busy);
    end
    clr = 1'b0;
    tick(2);
    total++;
    if (busy !== 1'b0 || rx_done !== 1'b0 || frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got=%b/%b/%b want=0/0/0", busy, rx_done, frame_err);
    end
  endtask

  // 0x1C with exact strobe latency: high in the cycle after the stop-bit fall only.
  task automatic test_clean();
    int d0;
    int e0;
    d0 = n_done;
    e0 = n_err;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 10);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL clean busy_midframe got=%b want=1", busy);
    end
    ps2d = 1'b1;
    tick(2);
    ps2c = 1'b0;
    tick(1);
    total++;
    if (rx_done !== 1'b1 || frame_err !== 1'b0 || scan_code !== 8'h1C) begin
      bad++;
      $display("FAIL clean strobe got=%b/%b/%h want=1/0/1c", rx_done, frame_err, scan_code);
    end
    tick(1);
    total++;
    if (rx_done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clean one_cycle got=%b busy=%b want=0/0", rx_done, busy);
    end
    tick(2);
    ps2c = 1'b1;
    tick(2);
    model_code = 8'h1C;
    total++;
    if ((n_done - d0) !== 1 || (n_err - e0) !== 0) begin
      bad++;
      $display("FAIL clean counts got=%0d/%0d want=1/0", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_back_to_back();
    check_frame("b2b_f0", 8'hF0, 1'b1, 1'b1);
    check_frame("b2b_1c", 8'h1C, 1'b0, 1'b1);
  endtask

  task automatic test_parity_err();
    check_frame("parity_err", 8'h1C, 1'b1, 1'b1);
  endtask

  task automatic test_stop_err();
    check_frame("stop_err", 8'h1C, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    int d0;
    int e0;
    d0 = n_done;
    e0 = n_err;
    send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 5);
    tick(20);
    total++;
    if (busy !== 1'b1 || (n_err - e0) !== 0) begin
      bad++;
      $display("FAIL timeout early got busy=%b errs=%0d want=1/0", busy, n_err - e0);
    end
    tick(20);
    total++;
    if ((n_err - e0) !== 1 || (n_done - d0) !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout fired got errs=%0d dones=%0d busy=%b want=1/0/0", n_err - e0, n_done - d0, busy);
    end
    check_frame("timeout_recover", 8'h1C, 1'b0, 1'b1);
  endtask

  task automatic test_clr_midframe();
    int d0;
    int e0;
    d0 = n_done;
    e0 = n_err;
    send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 5);
    clr = 1'b1;
    tick(1);
    total++;
    if ({scan_code, rx_done, frame_err, busy} !== 11'h000) begin
      bad++;
      $display("FAIL clr_mid outputs got=%h/%b/%b/%b want=00/0/0/0", scan_code, rx_done, frame_err, busy);
    end
    clr = 1'b0;
    model_code = 8'h00;
    tick(TO + 10);
    total++;
    if ((n_done - d0) !== 0 || (n_err - e0) !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL clr_mid strobes got=%0d/%0d busy=%b want=0/0/0", n_done - d0, n_err - e0, busy);
    end
  endtask

  task automatic test_glitch_start();
    int d0;
    int e0;
    d0 = n_done;
    e0 = n_err;
    ps2d = 1'b1;
    tick(2);
    ps2c = 1'b0;
    tick(2);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch busy got=%b want=0", busy);
    end
    tick(2);
    ps2c = 1'b1;
    tick(TO + 4);
    total++;
    if ((n_done - d0) !== 0 || (n_err - e0) !== 0) begin
      bad++;
      $display("FAIL glitch strobes got=%0d/%0d want=0/0", n_done - d0, n_err - e0);
    end
    check_frame("glitch_recover", 8'hA5, odd_par(8'hA5), 1'b1);
  endtask

  task automatic test_rx_en_gate();
    int d0;
    int e0;
    d0 = n_done;
    e0 = n_err;
    rx_en = 1'b0;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), PS2_FRAME_BITS);
    tick(4);
    total++;
    if ((n_done - d0) !== 0 || (n_err - e0) !== 0 || busy !== 1'b0 || scan_code !== model_code) begin
      bad++;
      $display("FAIL rx_en_gate got=%0d/%0d busy=%b code=%h want=0/0/0/%h",
               n_done - d0, n_err - e0, busy, scan_code, model_code);
    end
    rx_en = 1'b1;
  endtask

  // Dropping rx_en after the start bit must not abort the frame in flight.
  task automatic test_rx_en_midframe();
    logic [10:0] f;
    int d0;
    d0 = n_done;
    f  = mk_frame(8'h3C, odd_par(8'h3C), 1'b1);
    send_bits(f, 1);
    rx_en = 1'b0;
    send_bits(f >> 1, PS2_FRAME_BITS - 1);
    tick(2);
    total++;
    if ((n_done - d0) !== 1 || scan_code !== 8'h3C) begin
      bad++;
      $display("FAIL rx_en_mid got=%0d code=%h want=1/3c", n_done - d0, scan_code);
    end
    model_code = 8'h3C;
    rx_en = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       perr;
    logic       serr;
    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom);
      perr = ($urandom_range(0, 3) == 0);
      serr = ($urandom_range(0, 7) == 0);
      check_frame($sformatf("random%0d", k), d, odd_par(d) ^ perr, ~serr);
      if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 10));
    end
  endtask

  task automatic test_pulse_shape();
    total++;
    if (n_long !== 0) begin
      bad++;
      $display("FAIL pulse_width stretched_strobes got=%0d want=0", n_long);
    end
    total++;
    if (n_both !== 0) begin
      bad++;
      $display("FAIL pulse_exclusive overlaps got=%0d want=0", n_both);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_back_to_back();
    test_parity_err();
    test_stop_err();
    test_timeout();
    test_clr_midframe();
    test_glitch_start();
    test_rx_en_gate();
    test_rx_en_midframe();
    test_random();
    test_pulse_shape();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
